// File: rtl/touch_frame_parser.sv
// Touch frame parser: assembles 10-byte touch-panel bursts into clamped
// coordinate/gesture registers and presents each frame with a READY level
// pulse of fixed width followed by a guaranteed low gap. One frame can be
// held pending while a previous frame is still being presented.
module touch_frame_parser #(
  parameter int READY_WIDTH = 8,
  parameter int READY_GAP   = 4,
  parameter int X_MAX       = 799,
  parameter int Y_MAX       = 479
) (
  input  logic       iCLK,
  input  logic       iRSTN,
  input  logic       iFRAME_START,
  input  logic       iBYTE_VALID,
  input  logic [7:0] iBYTE,
  input  logic       iFRAME_END,
  output logic       oREADY,
  output logic [9:0] oREG_X1,
  output logic [8:0] oREG_Y1,
  output logic [9:0] oREG_X2,
  output logic [8:0] oREG_Y2,
  output logic [1:0] oREG_TOUCH_COUNT,
  output logic [7:0] oREG_GESTURE,
  output logic       oFRAME_ERR,
  output logic       oOVERRUN
);
  localparam logic [9:0] XM      = 10'(X_MAX);
  localparam logic [8:0] YM      = 9'(Y_MAX);
  localparam logic [7:0] RW_LAST = 8'(READY_WIDTH - 1);
  localparam logic [7:0] RG_LAST = 8'(READY_GAP - 1);

  typedef enum logic       {P_IDLE, P_RECV} pstate_t;
  typedef enum logic [1:0] {O_IDLE, O_HIGH, O_GAP} ostate_t;

  // Only the meaningful bits of each burst byte are kept.
  typedef struct packed {
    logic [7:0] gest;
    logic [1:0] cnt;
    logic [1:0] x1h; logic [7:0] x1l;
    logic       y1h; logic [7:0] y1l;
    logic [1:0] x2h; logic [7:0] x2l;
    logic       y2h; logic [7:0] y2l;
  } raw_t;

  typedef struct packed {
    logic [9:0] x1;
    logic [8:0] y1;
    logic [9:0] x2;
    logic [8:0] y2;
    logic [1:0] cnt;
    logic [7:0] gest;
  } frame_t;

  function automatic logic [9:0] clamp_x(input logic [1:0] hi, input logic [7:0] lo);
    logic [9:0] v;
    v = {hi, lo};
    return (v > XM) ? XM : v;
  endfunction

  function automatic logic [8:0] clamp_y(input logic hi, input logic [7:0] lo);
    logic [8:0] v;
    v = {hi, lo};
    return (v > YM) ? YM : v;
  endfunction

  pstate_t    p_q, p_nx;
  logic [3:0] bcnt_q, bcnt_nx, wr_idx;
  raw_t       raw_q, raw_nx;
  logic       wr, commit, err_nx;
  frame_t     cframe;

  ostate_t    o_q, o_nx;
  logic [7:0] ocnt_q, ocnt_nx;
  frame_t     pend_q, pend_nx, out_q, out_nx;
  logic       pend_v_q, pend_v_nx, ready_q, ready_nx, ovr_nx, load;
  logic       err_q, ovr_q;

  // Parser: byte counting, field capture and commit/error decision.
  always_comb begin
    p_nx    = p_q;
    bcnt_nx = bcnt_q;
    raw_nx  = raw_q;
    commit  = 1'b0;
    err_nx  = 1'b0;
    wr      = 1'b0;
    wr_idx  = bcnt_q;
    if (iFRAME_START) begin
      // A restart silently drops any partial frame.
      p_nx    = P_RECV;
      bcnt_nx = '0;
      wr_idx  = '0;
      if (iBYTE_VALID) begin
        wr      = 1'b1;
        bcnt_nx = 4'd1;
      end
    end else if (p_q == P_RECV) begin
      if (iBYTE_VALID && bcnt_q < 4'd10) begin
        wr      = 1'b1;
        bcnt_nx = bcnt_q + 4'd1;
      end
      if (iFRAME_END) begin
        p_nx = P_IDLE;
        if (bcnt_nx == 4'd10) commit = 1'b1;
        else                  err_nx = 1'b1;
      end
    end
    if (wr) begin
      case (wr_idx)
        4'd0: raw_nx.gest = iBYTE;
        4'd1: raw_nx.cnt  = iBYTE[1:0];
        4'd2: raw_nx.x1h  = iBYTE[1:0];
        4'd3: raw_nx.x1l  = iBYTE;
        4'd4: raw_nx.y1h  = iBYTE[0];
        4'd5: raw_nx.y1l  = iBYTE;
        4'd6: raw_nx.x2h  = iBYTE[1:0];
        4'd7: raw_nx.x2l  = iBYTE;
        4'd8: raw_nx.y2h  = iBYTE[0];
        4'd9: raw_nx.y2l  = iBYTE;
        default: ;
      endcase
    end
    // Assemble from the next-state bytes so a last byte on the END cycle counts.
    cframe.gest = raw_nx.gest;
    cframe.cnt  = raw_nx.cnt;
    cframe.x1   = clamp_x(raw_nx.x1h, raw_nx.x1l);
    cframe.y1   = clamp_y(raw_nx.y1h, raw_nx.y1l);
    cframe.x2   = clamp_x(raw_nx.x2h, raw_nx.x2l);
    cframe.y2   = clamp_y(raw_nx.y2h, raw_nx.y2l);
  end

  // Presenter: READY width/gap sequencing and the single pending slot.
  always_comb begin
    o_nx      = o_q;
    ocnt_nx   = ocnt_q;
    ready_nx  = ready_q;
    pend_nx   = pend_q;
    pend_v_nx = pend_v_q;
    out_nx    = out_q;
    ovr_nx    = 1'b0;
    load      = 1'b0;
    case (o_q)
      O_IDLE: load = pend_v_q | commit;
      O_HIGH: begin
        if (ocnt_q == RW_LAST) begin
          o_nx     = O_GAP;
          ocnt_nx  = '0;
          ready_nx = 1'b0;
        end else ocnt_nx = ocnt_q + 8'd1;
      end
      O_GAP: begin
        // Loading straight out of the gap keeps the low time exactly READY_GAP.
        if (ocnt_q == RG_LAST) begin
          if (pend_v_q | commit) load = 1'b1;
          else                   o_nx = O_IDLE;
        end else ocnt_nx = ocnt_q + 8'd1;
      end
      default: o_nx = O_IDLE;
    endcase
    if (load) begin
      o_nx     = O_HIGH;
      ocnt_nx  = '0;
      ready_nx = 1'b1;
      out_nx   = pend_v_q ? pend_q : cframe;
    end
    if (load && pend_v_q) begin
      pend_v_nx = commit;
      pend_nx   = cframe;
    end else if (commit && !load) begin
      ovr_nx    = pend_v_q;
      pend_nx   = cframe;
      pend_v_nx = 1'b1;
    end
  end

  // State registers for both machines and the registered pulse outputs.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      p_q      <= P_IDLE;
      bcnt_q   <= '0;
      raw_q    <= '0;
      o_q      <= O_IDLE;
      ocnt_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      out_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      p_q      <= p_nx;
      bcnt_q   <= bcnt_nx;
      raw_q    <= raw_nx;
      o_q      <= o_nx;
      ocnt_q   <= ocnt_nx;
      pend_q   <= pend_nx;
      pend_v_q <= pend_v_nx;
      out_q    <= out_nx;
      ready_q  <= ready_nx;
      err_q    <= err_nx;
      ovr_q    <= ovr_nx;
    end
  end

  assign oREADY           = ready_q;
  assign oREG_X1          = out_q.x1;
  assign oREG_Y1          = out_q.y1;
  assign oREG_X2          = out_q.x2;
  assign oREG_Y2          = out_q.y2;
  assign oREG_TOUCH_COUNT = out_q.cnt;
  assign oREG_GESTURE     = out_q.gest;
  assign oFRAME_ERR       = err_q;
  assign oOVERRUN         = ovr_q;
endmodule

// File: tb/tb_touch_frame_parser.sv
// Self-checking bench for touch_frame_parser: a cycle-indexed behavioural
// model (byte queue + READY timeline) checked every cycle, plus literal
// expectations for the directed scenarios.
module tb_touch_frame_parser;
  localparam int W = 24;  // wide enough for two bursts to commit during one pulse
  localparam int G = 4;

  logic       iCLK = 1'b0, iRSTN = 1'b1;
  logic       iFRAME_START = 1'b0, iBYTE_VALID = 1'b0, iFRAME_END = 1'b0;
  logic [7:0] iBYTE = '0;
  logic       oREADY, oFRAME_ERR, oOVERRUN;
  logic [9:0] oREG_X1, oREG_X2;
  logic [8:0] oREG_Y1, oREG_Y2;
  logic [1:0] oREG_TOUCH_COUNT;
  logic [7:0] oREG_GESTURE;

  touch_frame_parser #(.READY_WIDTH(W), .READY_GAP(G)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iFRAME_START(iFRAME_START),
    .iBYTE_VALID(iBYTE_VALID), .iBYTE(iBYTE), .iFRAME_END(iFRAME_END),
    .oREADY(oREADY), .oREG_X1(oREG_X1), .oREG_Y1(oREG_Y1),
    .oREG_X2(oREG_X2), .oREG_Y2(oREG_Y2), .oREG_TOUCH_COUNT(oREG_TOUCH_COUNT),
    .oREG_GESTURE(oREG_GESTURE), .oFRAME_ERR(oFRAME_ERR), .oOVERRUN(oOVERRUN)
  );

  always #5 iCLK = ~iCLK;

  int vectors = 0, miscompares = 0, ovr_seen = 0;

  typedef struct { int g, c, x1, y1, x2, y2; } frm_t;

  // ---------------- behavioural model ----------------
  int   q[$];
  bit   inb = 0, pv = 0, e_err = 0, e_ovr = 0, e_rdy = 0;
  frm_t pf, e_f, cf;
  longint cyc = 0, fall_at = 0, next_ok = 0;

  function automatic int clx(int hi, int lo);
    int v = (hi % 4) * 256 + lo;
    return (v > 799) ? 799 : v;
  endfunction
  function automatic int cly(int hi, int lo);
    int v = (hi % 2) * 256 + lo;
    return (v > 479) ? 479 : v;
  endfunction

  function automatic frm_t zero_f();
    frm_t f;
    f.g = 0; f.c = 0; f.x1 = 0; f.y1 = 0; f.x2 = 0; f.y2 = 0;
    return f;
  endfunction

  // Compare this cycle's outputs, then advance the model with the inputs
  // that the next rising edge will sample.
  always @(negedge iCLK) begin
    logic [50:0] got, want;
    bit commit;
    longint n;
    got = {oREADY, oREG_X1, oREG_Y1, oREG_X2, oREG_Y2, oREG_TOUCH_COUNT,
           oREG_GESTURE, oFRAME_ERR, oOVERRUN};
    if (!iRSTN) want = '0;
    else want = {e_rdy, 10'(e_f.x1), 9'(e_f.y1), 10'(e_f.x2), 9'(e_f.y2),
                 2'(e_f.c), 8'(e_f.g), e_err, e_ovr};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t: got %h want %h", $time, got, want);
    end
    if (iRSTN && oOVERRUN) ovr_seen++;

    if (!iRSTN) begin
      q.delete(); inb = 0; pv = 0; e_err = 0; e_ovr = 0; e_rdy = 0;
      e_f = zero_f(); fall_at = 0; next_ok = 0;
    end else begin
      n = cyc + 1;
      e_err = 0; e_ovr = 0; commit = 0;
      if (iFRAME_START) begin
        q.delete(); inb = 1;
        if (iBYTE_VALID) q.push_back(int'(iBYTE));
      end else if (inb) begin
        if (iBYTE_VALID) q.push_back(int'(iBYTE));
        if (iFRAME_END) begin
          inb = 0;
          if (q.size() >= 10) begin
            commit = 1;
            cf.g = q[0]; cf.c = q[1] % 4;
            cf.x1 = clx(q[2], q[3]); cf.y1 = cly(q[4], q[5]);
            cf.x2 = clx(q[6], q[7]); cf.y2 = cly(q[8], q[9]);
          end else e_err = 1;
        end
      end
      // A frame may rise as soon as the previous pulse plus its gap has elapsed.
      if ((pv || commit) && n >= next_ok) begin
        if (pv) begin e_f = pf; pv = commit; pf = cf; end
        else e_f = cf;
        fall_at = n + W;
        next_ok = n + W + G;
      end else if (commit) begin
        e_ovr = pv; pf = cf; pv = 1;
      end
      e_rdy = (n < fall_at);
    end
    cyc = cyc + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge iCLK); #1;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // bb holds b0 in [7:0]; sends n bytes, START with the first, END with the last if fin.
  task automatic burst(input logic [79:0] bb, input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      iFRAME_START = (i == 0);
      iBYTE_VALID  = 1'b1;
      iBYTE        = bb[8*i +: 8];
      iFRAME_END   = fin && (i == n - 1);
      step();
    end
    iFRAME_START = 0; iBYTE_VALID = 0; iFRAME_END = 0; iBYTE = '0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // {b9,...,b0}
  localparam logic [79:0] B1 = {8'h00,8'h00,8'h00,8'h00,8'hAB,8'h00,8'h23,8'h01,8'h01,8'h18};
  localparam logic [79:0] B2 = {8'h05,8'hFE,8'h10,8'hFE,8'hFF,8'h01,8'hFF,8'h03,8'h02,8'h22};
  localparam logic [79:0] BA = {8'h00,8'h00,8'h00,8'h00,8'h10,8'h00,8'h10,8'h00,8'h01,8'h0A};
  localparam logic [79:0] BB = {8'h00,8'h00,8'h00,8'h00,8'h20,8'h00,8'h20,8'h00,8'h01,8'h0B};
  localparam logic [79:0] BC = {8'h00,8'h00,8'h00,8'h00,8'h30,8'h00,8'h30,8'h00,8'h01,8'h0C};
  localparam logic [79:0] BE = {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h05,8'h00,8'h00,8'h00};

  initial begin
    int hc, lc, base;
    #1 iRSTN = 1'b0;
    idle(3);
    chk("reset_ready", int'(oREADY), 0);
    chk("reset_gesture", int'(oREG_GESTURE), 0);
    iRSTN = 1'b1;
    idle(2);

    // single burst: presented at T+1, high for W cycles
    burst(B1, 10, 1);
    chk("b1_ready", int'(oREADY), 1);
    chk("b1_gesture", int'(oREG_GESTURE), 8'h18);
    chk("b1_x1", int'(oREG_X1), 291);
    chk("b1_y1", int'(oREG_Y1), 171);
    chk("b1_count", int'(oREG_TOUCH_COUNT), 1);
    hc = 0;
    while (oREADY && hc < 100) begin hc++; step(); end
    chk("b1_high_cycles", hc, W);
    idle(8);

    // clamping and ignored high bits
    burst(B2, 10, 1);
    chk("clamp_x1", int'(oREG_X1), 799);
    chk("clamp_y1", int'(oREG_Y1), 479);
    chk("mask_x2", int'(oREG_X2), 528);
    chk("mask_y2", int'(oREG_Y2), 5);
    idle(W + G + 4);

    // short frame
    burst(B1, 7, 1);
    chk("short_err", int'(oFRAME_ERR), 1);
    chk("short_ready", int'(oREADY), 0);
    chk("short_gesture_kept", int'(oREG_GESTURE), 8'h22);
    step();
    chk("short_err_one_cycle", int'(oFRAME_ERR), 0);
    idle(3);

    // restart mid-burst then full burst
    burst(B2, 4, 0);
    burst(B1, 10, 1);
    chk("restart_err", int'(oFRAME_ERR), 0);
    chk("restart_gesture", int'(oREG_GESTURE), 8'h18);
    idle(W + G + 4);

    // A, then B and C commit while A is high; C overwrites B
    base = ovr_seen;
    burst(BA, 10, 1);
    chk("abc_a_gesture", int'(oREG_GESTURE), 8'h0A);
    burst(BB, 10, 1);
    burst(BC, 10, 1);
    hc = 0;
    while (oREADY && hc < 100) begin hc++; step(); end
    lc = 0;
    while (!oREADY && lc < 100) begin lc++; step(); end
    chk("abc_gap_cycles", lc, G);
    chk("abc_c_gesture", int'(oREG_GESTURE), 8'h0C);
    chk("abc_c_x1", int'(oREG_X1), 48);
    chk("abc_overruns", ovr_seen - base, 1);
    idle(W + G + 4);

    // reset during high, then a zero gesture/count frame after release
    burst(B1, 10, 1);
    idle(3);
    iRSTN = 1'b0;
    #1;
    chk("rst_mid_ready", int'(oREADY), 0);
    chk("rst_mid_x1", int'(oREG_X1), 0);
    chk("rst_mid_gesture", int'(oREG_GESTURE), 0);
    idle(2);
    iRSTN = 1'b1;
    idle(2);
    burst(BE, 10, 1);
    chk("post_rst_ready", int'(oREADY), 1);
    chk("post_rst_x1", int'(oREG_X1), 5);
    chk("post_rst_count", int'(oREG_TOUCH_COUNT), 0);
    idle(W + G + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
